// File: rtl/spi_master_param_m_if.sv
// rtl/spi_master_param_m_if.sv - host-side request/response bundle for spi_master_param_m
interface spi_master_param_m_if #(
   parameter int WIDTH = 8,
   parameter int CSW   = 1,
   parameter int DIV_W = 8
);
   logic             start;
   logic [1:0]       mode;
   logic [DIV_W-1:0] div;
   logic             lsb_first;
   logic [CSW-1:0]   cs_sel;
   logic [WIDTH-1:0] dout;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;

   modport master (
      output start, mode, div, lsb_first, cs_sel, dout,
      input  din, busy, done
   );

   modport slave (
      input  start, mode, div, lsb_first, cs_sel, dout,
      output din, busy, done
   );
endinterface

// File: rtl/spi_master_param_m.sv
// rtl/spi_master_param_m.sv - parametrised SPI master with registered SCK and word-at-a-time transfers
module spi_master_param_m #(
   parameter int WIDTH  = 8,
   parameter int N_CS   = 1,
   parameter int CSW    = 1,
   parameter int DIV_W  = 8,
   parameter int T_PRE  = 0,
   parameter int T_POST = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_master_param_m_if.slave  host,
   output logic [N_CS-1:0]      cs_n,
   output logic                 sck,
   input  logic                 miso,
   output logic                 mosi
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PRE  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_POST = 2'd3;

   // Last half-period index of each phase; XFER spans 2*WIDTH half-periods, one SCK edge at the start of each.
   localparam logic [15:0] PRE_LAST  = 16'(T_PRE);
   localparam logic [15:0] XFER_LAST = 16'(2 * WIDTH - 1);
   localparam logic [15:0] POST_LAST = 16'(T_POST);

   logic [1:0]       state;
   logic [DIV_W-1:0] hcnt;
   logic [DIV_W-1:0] div_q;
   logic [15:0]      pcnt;
   logic             cpol_q;
   logic             cpha_q;
   logic             lsb_q;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;

   logic             tick;
   logic             edge_now;
   logic             leading;
   logic             last_edge;
   logic             tx_bit;
   logic [WIDTH-1:0] tx_next;
   logic [WIDTH-1:0] rx_next;
   logic [N_CS-1:0]  cs_dec;

   // One-hot chip-select decode; an index beyond N_CS matches no line.
   always_comb begin
      cs_dec = '0;
      for (int i = 0; i < N_CS; i++) begin
         cs_dec[i] = (host.cs_sel == CSW'(i));
      end
   end

   // Half-period timing, SCK edge detection and shift-register next values.
   always_comb begin
      tick     = (hcnt == div_q);
      edge_now = 1'b0;
      if (tick && state == S_PRE && pcnt == PRE_LAST) begin
         edge_now = 1'b1;
      end
      if (tick && state == S_XFER && pcnt != XFER_LAST) begin
         edge_now = 1'b1;
      end
      leading   = (sck == cpol_q);
      last_edge = (state == S_XFER) && (pcnt == XFER_LAST - 16'd1);
      tx_bit    = lsb_q ? tx_sr[0] : tx_sr[WIDTH-1];
      tx_next   = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
      rx_next   = lsb_q ? {miso, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], miso};
   end

   // Transfer sequencer: IDLE -> PRE -> XFER -> POST -> IDLE, all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         hcnt      <= '0;
         div_q     <= '0;
         pcnt      <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         host.din  <= '0;
         host.busy <= 1'b0;
         host.done <= 1'b0;
         cs_n      <= '1;
         sck       <= 1'b0;
         mosi      <= 1'b0;
      end else begin
         host.done <= 1'b0;
         if (state == S_IDLE) begin
            sck  <= host.mode[1];
            mosi <= 1'b0;
            hcnt <= '0;
            pcnt <= '0;
            if (host.start) begin
               state     <= S_PRE;
               host.busy <= 1'b1;
               cpol_q    <= host.mode[1];
               cpha_q    <= host.mode[0];
               div_q     <= host.div;
               lsb_q     <= host.lsb_first;
               cs_n      <= ~cs_dec;
               if (!host.mode[0]) begin
                  // CPHA=0 needs the first bit on MOSI before the first (sampling) edge.
                  mosi  <= host.lsb_first ? host.dout[0] : host.dout[WIDTH-1];
                  tx_sr <= host.lsb_first ? (host.dout >> 1) : (host.dout << 1);
               end else begin
                  tx_sr <= host.dout;
               end
            end
         end else begin
            hcnt <= tick ? '0 : hcnt + DIV_W'(1);
            if (edge_now) begin
               sck <= ~sck;
               if (leading ^ cpha_q) begin
                  rx_sr <= rx_next;
               end
               if (cpha_q ? leading : (!leading && !last_edge)) begin
                  mosi  <= tx_bit;
                  tx_sr <= tx_next;
               end
            end
            if (tick) begin
               case (state)
                  S_PRE: begin
                     if (pcnt == PRE_LAST) begin
                        state <= S_XFER;
                        pcnt  <= '0;
                     end else begin
                        pcnt <= pcnt + 16'd1;
                     end
                  end
                  S_XFER: begin
                     if (pcnt == XFER_LAST) begin
                        state <= S_POST;
                        pcnt  <= '0;
                     end else begin
                        pcnt <= pcnt + 16'd1;
                     end
                  end
                  default: begin
                     if (pcnt == POST_LAST) begin
                        state     <= S_IDLE;
                        pcnt      <= '0;
                        host.busy <= 1'b0;
                        host.done <= 1'b1;
                        host.din  <= rx_sr;
                        cs_n      <= '1;
                        mosi      <= 1'b0;
                     end else begin
                        pcnt <= pcnt + 16'd1;
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_param_m.sv
// tb/tb_spi_master_param_m.sv - table-driven bench for spi_master_param_m with per-mode slave models
module tb_spi_master_param_m;

   logic clk;
   logic rst_n;

   spi_master_param_m_if #(.WIDTH(8),  .CSW(2), .DIV_W(8)) if0 ();
   spi_master_param_m_if #(.WIDTH(16), .CSW(2), .DIV_W(8)) if1 ();

   logic [3:0] cs_n0;
   logic [2:0] cs_n1;
   logic       sck0, sck1, mosi0, mosi1;
   logic [1:0] miso_v;

   spi_master_param_m #(.WIDTH(8), .N_CS(4), .CSW(2), .DIV_W(8), .T_PRE(0), .T_POST(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .host(if0), .cs_n(cs_n0), .sck(sck0), .miso(miso_v[0]), .mosi(mosi0)
   );

   spi_master_param_m #(.WIDTH(16), .N_CS(3), .CSW(2), .DIV_W(8), .T_PRE(1), .T_POST(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .host(if1), .cs_n(cs_n1), .sck(sck1), .miso(miso_v[1]), .mosi(mosi1)
   );

   always #5 clk = ~clk;

   logic [1:0]  busy_v, done_v, sck_v, mosi_v;
   logic [31:0] din_v [2];
   logic [3:0]  csn_v [2];
   assign busy_v   = {if1.busy, if0.busy};
   assign done_v   = {if1.done, if0.done};
   assign sck_v    = {sck1, sck0};
   assign mosi_v   = {mosi1, mosi0};
   assign din_v[0] = 32'(if0.din);
   assign din_v[1] = 32'(if1.din);
   assign csn_v[0] = cs_n0;
   assign csn_v[1] = {1'b1, cs_n1};

   // Slave model state, one slot per DUT
   logic [31:0] s_word [2];
   logic [31:0] s_mosi [2];
   int          s_w    [2];
   int          s_edges[2];
   logic        s_lsb  [2];
   logic        s_cpha [2];
   logic        s_prev [2];

   int n_vec;
   int n_err;

   function automatic logic s_bit(input int d, input int i);
      return s_lsb[d] ? s_word[d][i] : s_word[d][s_w[d] - 1 - i];
   endfunction

   // Slave reacts half a CLK after each SCK edge: drives MISO on its shift edges, records MOSI on sampling edges.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!busy_v[d]) begin
            s_edges[d] = 0;
            miso_v[d]  = s_cpha[d] ? 1'b0 : s_bit(d, 0);
         end else if (sck_v[d] != s_prev[d]) begin
            s_edges[d] = s_edges[d] + 1;
            if (s_edges[d] % 2 == 1) begin
               if (s_cpha[d]) miso_v[d] = s_bit(d, (s_edges[d] - 1) / 2);
               else           s_mosi[d] = {s_mosi[d][30:0], mosi_v[d]};
            end else begin
               if (s_cpha[d])                   s_mosi[d] = {s_mosi[d][30:0], mosi_v[d]};
               else if (s_edges[d] / 2 < s_w[d]) miso_v[d] = s_bit(d, s_edges[d] / 2);
            end
         end
         s_prev[d] = sck_v[d];
      end
   end

   typedef struct {
      int          d;
      logic [1:0]  mode;
      logic [7:0]  div;
      logic        lsb;
      logic [1:0]  cs;
      logic [31:0] dout;
      logic [31:0] sword;
      logic [31:0] exp_din;
      logic [31:0] exp_seq;
      int          exp_busy;
      int          exp_first;
      int          exp_half;
      logic [3:0]  exp_cs;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic [1:0] m, input logic [7:0] dv, input logic l,
                        input logic [1:0] cs, input logic [31:0] dout, input logic st);
      if (d == 0) begin
         if0.mode = m; if0.div = dv; if0.lsb_first = l; if0.cs_sel = cs; if0.dout = dout[7:0]; if0.start = st;
      end else begin
         if1.mode = m; if1.div = dv; if1.lsb_first = l; if1.cs_sel = cs; if1.dout = dout[15:0]; if1.start = st;
      end
   endtask

   task automatic set_slave(input int d, input logic [31:0] w, input logic l, input logic cpha);
      s_word[d] = w;
      s_w[d]    = (d == 0) ? 8 : 16;
      s_lsb[d]  = l;
      s_cpha[d] = cpha;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          c;
      int          first_e;
      int          second_e;
      logic        prev_sck;
      logic [3:0]  cs_seen;
      logic [31:0] mask;
      mask = (v.d == 0) ? 32'hFF : 32'hFFFF;
      set_slave(v.d, v.sword, v.lsb, v.mode[0]);
      @(negedge clk);
      drive(v.d, v.mode, v.div, v.lsb, v.cs, v.dout, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d sck idle before", idx), 32'(sck_v[v.d]), 32'(v.mode[1]));
      if (v.d == 0) if0.start = 1'b1; else if1.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (v.d == 0) if0.start = 1'b0; else if1.start = 1'b0;
      c = 0; first_e = -1; second_e = -1;
      cs_seen  = csn_v[v.d];
      prev_sck = sck_v[v.d];
      while (busy_v[v.d] && c < 4000) begin
         @(negedge clk);
         c++;
         if (sck_v[v.d] != prev_sck) begin
            if (first_e < 0)       first_e  = c;
            else if (second_e < 0) second_e = c;
            prev_sck = sck_v[v.d];
         end
      end
      check($sformatf("v%0d cs_n active", idx), 32'(cs_seen), 32'(v.exp_cs));
      check($sformatf("v%0d busy cycles", idx), 32'(c), 32'(v.exp_busy));
      check($sformatf("v%0d first sck edge", idx), 32'(first_e), 32'(v.exp_first));
      check($sformatf("v%0d half period", idx), 32'(second_e - first_e), 32'(v.exp_half));
      check($sformatf("v%0d done at end", idx), 32'(done_v[v.d]), 32'd1);
      check($sformatf("v%0d din", idx), din_v[v.d], v.exp_din);
      check($sformatf("v%0d cs_n released", idx), 32'(csn_v[v.d]), 32'hF);
      check($sformatf("v%0d mosi idle", idx), 32'(mosi_v[v.d]), 32'd0);
      check($sformatf("v%0d mosi bits", idx), s_mosi[v.d] & mask, v.exp_seq);
      @(negedge clk);
      check($sformatf("v%0d done pulse width", idx), 32'(done_v[v.d]), 32'd0);
      check($sformatf("v%0d sck idle after", idx), 32'(sck_v[v.d]), 32'(v.mode[1]));
      repeat (2) @(negedge clk);
      check($sformatf("v%0d din held", idx), din_v[v.d], v.exp_din);
   endtask

   logic [41:0] bb_busy, bb_done, bb_cs;
   int          n_done;

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      n_vec = 0; n_err = 0;
      drive(0, 2'b00, 8'd0, 1'b0, 2'd0, 32'd0, 1'b0);
      drive(1, 2'b00, 8'd0, 1'b0, 2'd0, 32'd0, 1'b0);
      for (int d = 0; d < 2; d++) begin
         set_slave(d, 32'd0, 1'b0, 1'b0);
         s_mosi[d] = 32'd0; s_edges[d] = 0; s_prev[d] = 1'b0;
      end

      //        d  mode   div   lsb   cs     dout          slave         exp_din       exp_seq      busy first half cs_n
      vecs[0] = '{0, 2'd0, 8'd0, 1'b0, 2'd0, 32'h00A5, 32'h003C, 32'h003C, 32'h00A5,  18, 1, 1, 4'b1110};
      vecs[1] = '{0, 2'd1, 8'd3, 1'b0, 2'd1, 32'h005A, 32'h00C3, 32'h00C3, 32'h005A,  72, 4, 4, 4'b1101};
      vecs[2] = '{0, 2'd2, 8'd3, 1'b0, 2'd2, 32'h000F, 32'h0096, 32'h0096, 32'h000F,  72, 4, 4, 4'b1011};
      vecs[3] = '{0, 2'd3, 8'd3, 1'b0, 2'd3, 32'h00F0, 32'h0081, 32'h0081, 32'h00F0,  72, 4, 4, 4'b0111};
      vecs[4] = '{1, 2'd0, 8'd1, 1'b1, 2'd0, 32'h8001, 32'h1234, 32'h1234, 32'h8001,  74, 4, 2, 4'b1110};
      vecs[5] = '{1, 2'd3, 8'd0, 1'b0, 2'd3, 32'h1234, 32'hABCD, 32'hABCD, 32'h1234,  37, 2, 1, 4'b1111};
      vecs[6] = '{1, 2'd1, 8'd2, 1'b1, 2'd1, 32'hBEEF, 32'hCAFE, 32'hCAFE, 32'hF77D, 111, 6, 3, 4'b1101};

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset%0d din", d),  din_v[d], 32'd0);
         check($sformatf("reset%0d busy", d), 32'(busy_v[d]), 32'd0);
         check($sformatf("reset%0d done", d), 32'(done_v[d]), 32'd0);
         check($sformatf("reset%0d cs_n", d), 32'(csn_v[d]), 32'hF);
         check($sformatf("reset%0d sck", d),  32'(sck_v[d]), 32'd0);
         check($sformatf("reset%0d mosi", d), 32'(mosi_v[d]), 32'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Back-to-back: START held through DONE, then a stray START pulse mid-transfer
      set_slave(0, 32'h3C, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 2'b00, 8'd0, 1'b0, 2'd0, 32'hA5, 1'b0);
      @(negedge clk);
      if0.start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 42; i++) begin
         @(negedge clk);
         bb_busy[i] = if0.busy;
         bb_done[i] = if0.done;
         bb_cs[i]   = cs_n0[0];
         if (i == 20) if0.start = 1'b0;
         if (i == 25) if0.start = 1'b1;
         if (i == 26) if0.start = 1'b0;
      end
      check("b2b busy before done",   32'(bb_busy[17]), 32'd1);
      check("b2b first done",         32'(bb_done[18]), 32'd1);
      check("b2b busy gap",           32'(bb_busy[18]), 32'd0);
      check("b2b cs low before gap",  32'(bb_cs[17]),   32'd0);
      check("b2b cs high in gap",     32'(bb_cs[18]),   32'd1);
      check("b2b cs low after gap",   32'(bb_cs[19]),   32'd0);
      check("b2b second busy",        32'(bb_busy[19]), 32'd1);
      check("b2b second busy end",    32'(bb_busy[36]), 32'd1);
      check("b2b second done",        32'(bb_done[37]), 32'd1);
      check("b2b no queued start",    32'(bb_busy[38] | bb_busy[41]), 32'd0);
      check("b2b done count",         32'($countones(bb_done)), 32'd2);
      check("b2b din",                din_v[0], 32'h3C);

      // Reset during XFER bit 4 of a mode-2 transfer
      set_slave(0, 32'h11, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 2'b10, 8'd3, 1'b0, 2'd1, 32'h5A, 1'b0);
      @(negedge clk);
      if0.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.start = 1'b0;
      repeat (38) @(negedge clk);
      check("rst mid busy", 32'(busy_v[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst din",  din_v[0], 32'd0);
      check("rst cs_n", 32'(csn_v[0]), 32'hF);
      check("rst sck",  32'(sck_v[0]), 32'd0);
      check("rst busy", 32'(busy_v[0]), 32'd0);
      check("rst mosi", 32'(mosi_v[0]), 32'd0);
      check("rst done", 32'(done_v[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_v[0]) n_done++;
      end
      check("rst no done pulse", 32'(n_done), 32'd0);
      run_vec(vecs[0], 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
